// File: rtl/mole_pkg.sv
// Shared types, sizes and the free-hole probe for the mole round controller.
// Used by the scheduler top, its interface and the per-hole life timers.
package mole_pkg;

   localparam int NUM_HOLES = 7;
   localparam int HOLE_W    = 3;
   localparam int LIFE_W    = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_e;

   typedef struct packed {
      logic              found;
      logic [HOLE_W-1:0] idx;
   } probe_t;

   // Start at the clamped counter value and walk downwards, wrapping
   // 0 -> 6, until a free hole is found.
   function automatic probe_t free_hole(
      input logic [NUM_HOLES-1:0] mask,
      input logic [3:0]           val
   );
      probe_t r;
      int     t;
      int     h;
      r = '0;
      t = (val > 4'd6) ? 6 : int'(val);
      for (int i = 0; i < NUM_HOLES; i++) begin
         h = t - i;
         if (h < 0) h = h + NUM_HOLES;
         if (!r.found && !mask[h]) begin
            r.found = 1'b1;
            r.idx   = HOLE_W'(h);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mole_spawn_scheduler_if.sv
// Game-side bundle of the mole scheduler: round control, ticks, whacks,
// hole-counter handshake, mask and score outputs. master = game, slave = DUT.
interface mole_spawn_scheduler_if #(
   parameter int CNT_W = 8
);
   import mole_pkg::*;

   logic                 start;
   logic                 spawn_tick;
   logic                 life_tick;
   logic                 whack_vld;
   logic [HOLE_W-1:0]    whack_idx;
   logic [3:0]           cntr_val;
   logic                 cntr_clr;
   logic                 cntr_cnt;
   logic [NUM_HOLES-1:0] mole_mask;
   logic [CNT_W-1:0]     hit_cnt;
   logic [CNT_W-1:0]     miss_cnt;
   logic                 busy;
   logic                 round_done;

   modport master (
      output start, spawn_tick, life_tick, whack_vld, whack_idx, cntr_val,
      input  cntr_clr, cntr_cnt, mole_mask, hit_cnt, miss_cnt, busy,
             round_done
   );

   modport slave (
      input  start, spawn_tick, life_tick, whack_vld, whack_idx, cntr_val,
      output cntr_clr, cntr_cnt, mole_mask, hit_cnt, miss_cnt, busy,
             round_done
   );

endinterface

// File: rtl/mole_life_timer.sv
// Lifetime down-counter for one hole: load_i arms it, tick_i ages it,
// kill_i (whack) empties it. Ports: clk, clr_n, load_i, tick_i, kill_i,
// active_o (hole occupied), expire_o (timer ran out this tick).
module mole_life_timer
   import mole_pkg::*;
#(
   parameter int LIFE = 5
) (
   input  logic clk,
   input  logic clr_n,
   input  logic load_i,
   input  logic tick_i,
   input  logic kill_i,
   output logic active_o,
   output logic expire_o
);

   logic [LIFE_W-1:0] cnt_q, cnt_d;

   // load wins over tick so a fresh mole starts at full lifetime
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LIFE_W'(LIFE);
      end else if (kill_i) begin
         cnt_d = '0;
      end else if (tick_i && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign active_o = (cnt_q != '0);
   // a whack in the same cycle turns the expiry into a hit
   assign expire_o = tick_i && !load_i && !kill_i &&
                     (cnt_q == LIFE_W'(1));

endmodule

// File: rtl/mole_spawn_scheduler.sv
// Whack-a-mole round controller: drives the hole-index counter, places
// moles on spawn ticks, ages them, resolves whacks and keeps the score.
// Ports: clk, clr_n (async active-low), mif (slave side of the bundle).
module mole_spawn_scheduler
   import mole_pkg::*;
#(
   parameter int ROUND_MOLES = 20,
   parameter int LIFE        = 5,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  clr_n,
   mole_spawn_scheduler_if.slave mif
);

   localparam logic [CNT_W-1:0] CMAX = '1;
   localparam logic [7:0]       RM   = 8'(ROUND_MOLES);

   state_e               state_q, state_d;
   logic [7:0]           spawned_q, spawned_d;
   logic [CNT_W-1:0]     hit_q, hit_d;
   logic [CNT_W-1:0]     miss_q, miss_d;
   logic                 clr_q, clr_d;

   logic [NUM_HOLES-1:0] mask;
   logic [NUM_HOLES-1:0] load;
   logic [NUM_HOLES-1:0] kill;
   logic [NUM_HOLES-1:0] expire;
   logic [2:0]           n_exp;
   logic [CNT_W+3:0]     miss_sum;
   probe_t               pr;
   logic                 in_play;
   logic                 spawn_go;
   logic                 whack_go;

   assign in_play = (state_q == RUN) || (state_q == DRAIN);

   // probe sees the mask from before this cycle's whack/expiry
   assign pr       = free_hole(mask, mif.cntr_val);
   assign spawn_go = (state_q == RUN) && mif.spawn_tick &&
                     (spawned_q != RM) && pr.found;
   assign whack_go = in_play && mif.whack_vld &&
                     (mif.whack_idx != 3'd7) && mask[mif.whack_idx];

   assign load = spawn_go ? (NUM_HOLES'(1) << pr.idx) : '0;
   assign kill = whack_go ? (NUM_HOLES'(1) << mif.whack_idx) : '0;

   for (genvar g = 0; g < NUM_HOLES; g++) begin : g_hole
      mole_life_timer #(
         .LIFE (LIFE)
      ) u_life (
         .clk      (clk),
         .clr_n    (clr_n),
         .load_i   (load[g]),
         .tick_i   (mif.life_tick),
         .kill_i   (kill[g]),
         .active_o (mask[g]),
         .expire_o (expire[g])
      );
   end

   always_comb begin
      n_exp = '0;
      for (int i = 0; i < NUM_HOLES; i++) begin
         n_exp = n_exp + 3'(expire[i]);
      end
   end

   assign miss_sum = (CNT_W+4)'(miss_q) + (CNT_W+4)'(n_exp);

   always_comb begin
      state_d   = state_q;
      clr_d     = 1'b0;
      spawned_d = spawned_q + 8'(spawn_go);
      hit_d     = (whack_go && hit_q != CMAX) ? hit_q + 1'b1 : hit_q;
      miss_d    = (miss_sum > (CNT_W+4)'(CMAX)) ? CMAX : miss_sum[CNT_W-1:0];
      unique case (state_q)
         IDLE: begin
            if (mif.start) begin
               state_d   = RUN;
               clr_d     = 1'b1;
               spawned_d = '0;
               hit_d     = '0;
               miss_d    = '0;
            end
         end
         RUN: begin
            if (spawned_q == RM) state_d = DRAIN;
         end
         DRAIN: begin
            if (mask == '0) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q   <= IDLE;
         spawned_q <= '0;
         hit_q     <= '0;
         miss_q    <= '0;
         clr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         spawned_q <= spawned_d;
         hit_q     <= hit_d;
         miss_q    <= miss_d;
         clr_q     <= clr_d;
      end
   end

   assign mif.cntr_clr   = clr_q;
   assign mif.cntr_cnt   = in_play;
   assign mif.busy       = in_play;
   assign mif.round_done = (state_q == DONE);
   assign mif.mole_mask  = mask;
   assign mif.hit_cnt    = hit_q;
   assign mif.miss_cnt   = miss_q;

endmodule

// File: tb/tb_mole_spawn_scheduler.sv
// Self-checking bench: two scheduler instances (different round size,
// lifetime and counter width) share stimulus and a per-hole lifetime model.
module tb_mole_spawn_scheduler;

   logic       clk = 1'b0;
   logic       clr_n = 1'b0;
   logic       start = 1'b0;
   logic       spawn_tick = 1'b0;
   logic       life_tick = 1'b0;
   logic       whack_vld = 1'b0;
   logic [2:0] whack_idx = '0;
   logic [3:0] cntr_val = '0;

   int n_chk = 0;
   int n_err = 0;

   mole_spawn_scheduler_if #(.CNT_W(8)) ia ();
   mole_spawn_scheduler_if #(.CNT_W(2)) ib ();

   assign ia.start      = start;
   assign ia.spawn_tick = spawn_tick;
   assign ia.life_tick  = life_tick;
   assign ia.whack_vld  = whack_vld;
   assign ia.whack_idx  = whack_idx;
   assign ia.cntr_val   = cntr_val;
   assign ib.start      = start;
   assign ib.spawn_tick = spawn_tick;
   assign ib.life_tick  = life_tick;
   assign ib.whack_vld  = whack_vld;
   assign ib.whack_idx  = whack_idx;
   assign ib.cntr_val   = cntr_val;

   mole_spawn_scheduler #(
      .ROUND_MOLES (3),
      .LIFE        (5),
      .CNT_W       (8)
   ) u_a (
      .clk   (clk),
      .clr_n (clr_n),
      .mif   (ia)
   );

   mole_spawn_scheduler #(
      .ROUND_MOLES (12),
      .LIFE        (3),
      .CNT_W       (2)
   ) u_b (
      .clk   (clk),
      .clr_n (clr_n),
      .mif   (ib)
   );

   always #5 clk = ~clk;

   // reference model: phase 0 idle, 1 spawning, 2 draining, 3 done
   int rm_p[2] = '{3, 12};
   int lf_p[2] = '{5, 3};
   int mx_p[2] = '{255, 3};
   int ph[2];
   int life[2][7];
   int hit[2];
   int miss[2];
   int spn[2];
   int clr[2];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic mdl_reset(input int k);
      ph[k] = 0; hit[k] = 0; miss[k] = 0; spn[k] = 0; clr[k] = 0;
      for (int i = 0; i < 7; i++) life[k][i] = 0;
   endtask

   task automatic mdl_step(input int k);
      bit occ[7];
      bit any;
      int sp, kl, t, h, spn0;
      any = 0; sp = -1; kl = -1; spn0 = spn[k];
      for (int i = 0; i < 7; i++) begin
         occ[i] = life[k][i] > 0;
         any = any | occ[i];
      end
      clr[k] = 0;
      if ((ph[k] == 1 || ph[k] == 2) && whack_vld && whack_idx < 7 &&
          occ[whack_idx]) kl = int'(whack_idx);
      if (ph[k] == 1 && spawn_tick && spn[k] < rm_p[k]) begin
         t = (cntr_val > 6) ? 6 : int'(cntr_val);
         for (int j = 0; j < 7; j++) begin
            h = (t - j + 7) % 7;
            if (sp < 0 && !occ[h]) sp = h;
         end
      end
      for (int i = 0; i < 7; i++) begin
         if (i == sp) life[k][i] = lf_p[k];
         else if (i == kl) begin
            life[k][i] = 0;
            if (hit[k] < mx_p[k]) hit[k]++;
         end else if (life_tick && life[k][i] > 0) begin
            life[k][i]--;
            if (life[k][i] == 0 && miss[k] < mx_p[k]) miss[k]++;
         end
      end
      if (sp >= 0) spn[k]++;
      case (ph[k])
         0: if (start) begin
            ph[k] = 1; clr[k] = 1; hit[k] = 0; miss[k] = 0; spn[k] = 0;
         end
         1: if (spn0 == rm_p[k]) ph[k] = 2;
         2: if (!any) ph[k] = 3;
         default: ph[k] = 0;
      endcase
   endtask

   function automatic logic [6:0] mdl_mask(input int k);
      logic [6:0] m;
      for (int i = 0; i < 7; i++) m[i] = life[k][i] > 0;
      return m;
   endfunction

   task automatic chk_one(input int k, input logic [6:0] m,
                          input logic [7:0] h, input logic [7:0] ms,
                          input logic b, input logic d,
                          input logic c, input logic n);
      string p;
      logic  play;
      p = (k == 0) ? "A" : "B";
      play = (ph[k] == 1 || ph[k] == 2);
      chk({p, ".mask"}, 32'(m), 32'(mdl_mask(k)));
      chk({p, ".hit"}, 32'(h), 32'(hit[k]));
      chk({p, ".miss"}, 32'(ms), 32'(miss[k]));
      chk({p, ".busy"}, 32'(b), 32'(play));
      chk({p, ".done"}, 32'(d), 32'(ph[k] == 3));
      chk({p, ".clr"}, 32'(c), 32'(clr[k]));
      chk({p, ".cnt"}, 32'(n), 32'(play));
   endtask

   task automatic chk_all();
      chk_one(0, ia.mole_mask, ia.hit_cnt, ia.miss_cnt, ia.busy,
              ia.round_done, ia.cntr_clr, ia.cntr_cnt);
      chk_one(1, ib.mole_mask, 8'(ib.hit_cnt), 8'(ib.miss_cnt), ib.busy,
              ib.round_done, ib.cntr_clr, ib.cntr_cnt);
   endtask

   task automatic cyc();
      @(posedge clk);
      if (!clr_n) begin
         mdl_reset(0); mdl_reset(1);
      end else begin
         mdl_step(0); mdl_step(1);
      end
      #1;
      chk_all();
   endtask

   task automatic idle_in();
      start = 0; spawn_tick = 0; life_tick = 0; whack_vld = 0;
   endtask

   task automatic spawn_at(input int v);
      idle_in();
      spawn_tick = 1; cntr_val = 4'(v);
      cyc();
   endtask

   // reset dropped between edges must clear outputs without a clock
   task automatic mid_reset();
      idle_in();
      #2 clr_n = 0;
      #1;
      mdl_reset(0); mdl_reset(1);
      chk_all();
      chk("rst.busy", 32'(ia.busy), 0);
      cyc();
      clr_n = 1;
   endtask

   initial begin
      mdl_reset(0); mdl_reset(1);
      repeat (2) @(posedge clk);
      #1;
      chk_all();
      chk("rst.mask", 32'(ia.mole_mask), 0);
      clr_n = 1;

      start = 1; spawn_tick = 1; cntr_val = 4'd2;
      cyc();
      chk("start.clr", 32'(ia.cntr_clr), 1);
      chk("start.busy", 32'(ia.busy), 1);
      chk("start.mask", 32'(ia.mole_mask), 0);
      idle_in();
      cyc();
      chk("run.clr", 32'(ia.cntr_clr), 0);
      chk("run.cnt", 32'(ia.cntr_cnt), 1);

      spawn_at(4);
      chk("sp4", 32'(ia.mole_mask), 32'h10);
      spawn_at(4);
      chk("sp4probe", 32'(ia.mole_mask), 32'h18);
      spawn_at(0);
      spawn_at(1);
      spawn_at(2);
      spawn_at(6);
      spawn_at(5);
      chk("full", 32'(ib.mole_mask), 32'h7f);
      chk("A.cap", 32'(ia.mole_mask), 32'h19);
      spawn_at(0);
      chk("fullskip", 32'(ib.mole_mask), 32'h7f);
      idle_in();
      whack_vld = 1; whack_idx = 3'd6;
      cyc();
      chk("whk6", 32'(ib.mole_mask), 32'h3f);
      chk("whkempty", 32'(ia.hit_cnt), 0);
      spawn_at(0);
      chk("wrap6", 32'(ib.mole_mask), 32'h7f);
      idle_in();
      whack_vld = 1; whack_idx = 3'd7;
      cyc();
      idle_in();
      for (int i = 0; i < 4; i++) begin
         life_tick = 1;
         cyc();
      end
      chk("B.sat", 32'(ib.miss_cnt), 3);
      chk("B.empty", 32'(ib.mole_mask), 0);
      life_tick = 1; whack_vld = 1; whack_idx = 3'd4;
      cyc();
      chk("lastwhk.hit", 32'(ia.hit_cnt), 1);
      chk("lastwhk.miss", 32'(ia.miss_cnt), 2);
      idle_in();
      cyc();
      chk("A.done", 32'(ia.round_done), 1);
      chk("A.donebusy", 32'(ia.busy), 0);
      cyc();
      chk("A.hold", 32'(ia.hit_cnt), 1);

      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(299) == 0) begin
            mid_reset();
         end else begin
            start      = ($urandom_range(19) == 0);
            spawn_tick = ($urandom_range(2) == 0);
            life_tick  = ($urandom_range(4) == 0);
            whack_vld  = ($urandom_range(2) == 0);
            whack_idx  = 3'($urandom_range(7));
            cntr_val   = 4'($urandom_range(15));
            cyc();
         end
      end

      idle_in();
      repeat (30) begin
         life_tick = 1;
         cyc();
      end
      idle_in();
      repeat (3) cyc();
      start = 1;
      cyc();
      spawn_at(3);
      spawn_at(3);
      chk("pre.rst", 32'(ia.mole_mask), 32'h0c);
      mid_reset();
      chk("post.rst", 32'(ia.round_done), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mole_spawn_scheduler.md
Name: mole_spawn_scheduler

Overview:
Round controller for the whack-a-mole game.
- Sequences the 7-state hole-index down counter: clears it at round start, then clocks it every cycle so its value acts as a pseudo-random hole index.
- Samples the counter on each spawn tick to place a mole, times each mole's lifetime, and resolves player whacks.
- Counts hits and misses for the score and display logic.

Parameters:
ROUND_MOLES, 20, number of moles spawned per round (1..255)
LIFE, 5, mole lifetime in life_tick pulses (1..15)
CNT_W, 8, width of hit_cnt and miss_cnt (saturating)

Ports:
clk  in  1  system clock
clr_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse, begins a round
spawn_tick  in  1  one-cycle pulse, spawn opportunity
life_tick  in  1  one-cycle pulse, decrements all mole lifetimes
whack_vld  in  1  player strike valid (already debounced, one-cycle)
whack_idx  in  3  struck hole 0..6
cntr_val  in  4  current value of the hole-index down counter (6..0)
cntr_clr  out  1  clear to the hole-index counter (active-high)
cntr_cnt  out  1  count enable to the hole-index counter
mole_mask  out  7  bit i = mole present in hole i
hit_cnt  out  CNT_W  hits this round
miss_cnt  out  CNT_W  expired moles this round
busy  out  1  round in progress
round_done  out  1  one-cycle pulse at end of round

Behaviour:
- Reset (clr_n=0, asynchronous): state IDLE. mole_mask, all lifetimes, hit_cnt, miss_cnt, spawned count, cntr_clr, cntr_cnt, busy and round_done all 0.
- States:
  - IDLE: start -> RUN. On that edge cntr_clr=1 for exactly one cycle, hit_cnt, miss_cnt and spawned are zeroed, busy goes 1.
  - RUN: spawns and whacks are active. When spawned reaches ROUND_MOLES -> DRAIN.
  - DRAIN: no new spawns. Whacks and expiries continue. When mole_mask==0 -> DONE.
  - DONE: round_done=1 and busy=0 for one cycle, then IDLE.
- cntr_cnt = 1 in RUN and DRAIN, 0 otherwise. cntr_clr and cntr_cnt are registered.
- start in any state other than IDLE is ignored.
- Spawn (RUN and spawn_tick):
  - Target index t = cntr_val; values above 6 are treated as 6.
  - If hole t is occupied in the current mask, probe t-1, t-2, ... wrapping 0->6. The first free hole is chosen.
  - The chosen bit is set on the next edge, its lifetime is loaded to LIFE, and spawned increments.
  - If all 7 holes are occupied, the spawn is skipped and spawned does not increment.
  - Spawn latency: 1 cycle, tick to mask bit.
- Lifetime: on life_tick, each occupied hole's timer decrements. When a timer goes 1->0 the bit clears and miss_cnt increments once per expiring hole. Multiple holes expiring in the same cycle add their popcount.
- Whack (RUN or DRAIN, whack_vld, whack_idx<=6, hole occupied): the bit clears and hit_cnt increments. A whack on an empty hole, with idx=7, or in IDLE/DONE has no effect.
- Simultaneous events:
  - Whack and expiry on the same hole in the same cycle: counted as a hit only.
  - Spawn probing uses the mask before that cycle's whack/expiry, so a hole vacated this cycle is not reused until the next cycle.
  - A spawn in a cycle with a life_tick loads LIFE without decrementing.
  - spawn_tick and start in the same cycle in IDLE: the spawn is ignored.
- hit_cnt and miss_cnt saturate at 2^CNT_W-1. Both hold their values after DONE until the next start.
- Reset mid-round: immediate return to IDLE with everything cleared. No round_done pulse.

Decomposition:
- Shared package mole_pkg:
  - NUM_HOLES=7
  - HOLE_W=3
  - state enum {IDLE, RUN, DRAIN, DONE}
  - LIFE_W=4
- Sub-module mole_life_timer, instantiated 7 times.
  - Inputs: load, tick, kill.
  - Outputs: active, expire pulse.
  - Internal: 4-bit down-counter.
- Free-hole probe is a combinational function in the package.

Test Plan:
- Reset then start: cntr_clr high one cycle after start, busy=1, cntr_cnt=1 thereafter, mask=0, counts=0.
- cntr_val=4, spawn_tick -> mole_mask=7'b0010000 next cycle. With hole 4 still full, cntr_val=4 again and spawn_tick -> bit 3 set (mask 7'b0011000).
- Holes 0..6 all full, cntr_val=0, spawn_tick -> mask unchanged, spawned unchanged. With only hole 6 free and cntr_val=0 -> wraps to hole 6.
- LIFE=5: spawn at hole 2, 5 life_ticks, no whack -> bit 2 clears on the 5th tick, miss_cnt=1, hit_cnt=0.
- Whack idx=2 in the same cycle as the final life_tick -> hit_cnt=1, miss_cnt=0. Whack on an empty hole -> no count change.
- ROUND_MOLES=3: 3 spawns then whack all -> DRAIN, then round_done pulse one cycle after mask empties, busy=0, hit_cnt=3. Assert clr_n low mid-RUN -> all outputs 0 at once, no round_done pulse.
